// File: rtl/result_serializer_pkg.sv
// Shared types and constants for the result serializer: FSM encoding, element
// geometry and the data byte count for an n x n result.
package result_serializer_pkg;

  localparam int unsigned ELEM_W  = 16;
  localparam int unsigned MAX_DIM = 3;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStrobe,
    StWaitHi,
    StWaitLo,
    StNext,
    StDone
  } state_e;

  // Data bytes for an n x n matrix of 16-bit elements (checksum excluded).
  function automatic logic [4:0] byte_count(input logic [1:0] n);
    logic [4:0] nn;
    nn = {3'b000, n};
    return (nn * nn) << 1;
  endfunction

endpackage

// File: rtl/result_serializer.sv
// Captures an n x n result matrix and streams it, row-major and high byte first,
// to an external UART transmitter followed by a modulo-256 checksum byte.
module result_serializer
  import result_serializer_pkg::*;
#(
  parameter int unsigned ELEM_W  = result_serializer_pkg::ELEM_W,
  parameter int unsigned MAX_DIM = result_serializer_pkg::MAX_DIM
) (
  input  logic                              bclk,
  input  logic                              rst,
  input  logic                              load,
  input  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] result,
  input  logic [3:0]                        size,
  input  logic                              tx_busy,
  output logic                              tx_start,
  output logic [7:0]                        tx_data,
  output logic                              busy,
  output logic                              done
);

  state_e                              state_q, state_d;
  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0]   shadow_q, shadow_d;
  logic [1:0]                          dim_q, dim_d;
  logic [1:0]                          row_q, row_d, row_n;
  logic [1:0]                          col_q, col_d, col_n;
  logic                                half_q, half_d, half_n;
  logic [4:0]                          idx_q, idx_d;
  logic [7:0]                          csum_q, csum_d;
  logic [7:0]                          tx_data_q, tx_data_d;
  logic [4:0]                          nbytes;
  logic [7:0]                          csum_sum;

  function automatic logic [7:0] pick_byte(input logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] sh,
                                           input logic [1:0] r, input logic [1:0] c,
                                           input logic lo);
    logic [ELEM_W-1:0] e;
    int unsigned       k;
    k = int'(r) * MAX_DIM + int'(c);
    e = sh[k*ELEM_W +: ELEM_W];
    return lo ? e[7:0] : e[ELEM_W-1 -: 8];
  endfunction

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    dim_d     = dim_q;
    row_d     = row_q;
    col_d     = col_q;
    half_d    = half_q;
    idx_d     = idx_q;
    csum_d    = csum_q;
    tx_data_d = tx_data_q;
    tx_start  = 1'b0;
    done      = 1'b0;
    nbytes    = byte_count(dim_q);
    csum_sum  = csum_q + tx_data_q;

    // Position of the byte following the current one; col wraps at n-1.
    row_n  = row_q;
    col_n  = col_q;
    half_n = ~half_q;
    if (half_q) begin
      if (col_q == dim_q - 2'd1) begin
        col_n = 2'd0;
        row_n = row_q + 2'd1;
      end else begin
        col_n = col_q + 2'd1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (load) begin
          shadow_d = result;
          dim_d    = ((size >= 4'd1) && (size <= 4'(MAX_DIM))) ? size[1:0] : 2'(MAX_DIM);
          state_d  = StLoad;
        end
      end
      StLoad: begin
        row_d     = 2'd0;
        col_d     = 2'd0;
        half_d    = 1'b0;
        idx_d     = 5'd0;
        csum_d    = 8'd0;
        tx_data_d = pick_byte(shadow_q, 2'd0, 2'd0, 1'b0);
        state_d   = StStrobe;
      end
      StStrobe: begin
        tx_start = 1'b1;
        state_d  = StWaitHi;
      end
      StWaitHi: begin
        if (tx_busy) state_d = StWaitLo;
      end
      StWaitLo: begin
        if (!tx_busy) state_d = StNext;
      end
      StNext: begin
        if (idx_q < nbytes) begin
          csum_d  = csum_sum;
          idx_d   = idx_q + 5'd1;
          row_d   = row_n;
          col_d   = col_n;
          half_d  = half_n;
          state_d = StStrobe;
          if (idx_q + 5'd1 < nbytes) begin
            tx_data_d = pick_byte(shadow_q, row_n, col_n, half_n);
          end else begin
            tx_data_d = csum_sum;
          end
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      shadow_q  <= '0;
      dim_q     <= 2'd0;
      row_q     <= 2'd0;
      col_q     <= 2'd0;
      half_q    <= 1'b0;
      idx_q     <= 5'd0;
      csum_q    <= 8'd0;
      tx_data_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      dim_q     <= dim_d;
      row_q     <= row_d;
      col_q     <= col_d;
      half_q    <= half_d;
      idx_q     <= idx_d;
      csum_q    <= csum_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign tx_data = tx_data_q;
  assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_result_serializer.sv
// Directed scoreboard bench for result_serializer with a simple UART transmitter model.
module tb_result_serializer;

  logic         bclk;
  logic         rst;
  logic         load;
  logic [143:0] result;
  logic [3:0]   size;
  logic         tx_busy;
  logic         tx_start;
  logic [7:0]   tx_data;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;
  int done_seen   = 0;
  int starts_seen = 0;
  int busy_len = 10;
  bit pre_hi   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] s3 [19];

  result_serializer dut (
    .bclk    (bclk),
    .rst     (rst),
    .load    (load),
    .result  (result),
    .size    (size),
    .tx_busy (tx_busy),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .busy    (busy),
    .done    (done)
  );

  initial begin
    bclk = 1'b0;
    forever #5 bclk = ~bclk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every tx_start pops one expected byte.
  always @(negedge bclk) begin
    if (tx_start) begin
      starts_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_tx_start", {24'd0, tx_data}, 32'hFFFF_FFFF);
      end else begin
        check("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      end
    end
    if (done) done_seen++;
  end

  // Transmitter model: busy for busy_len cycles per byte; in pre_hi mode busy is
  // re-raised between bytes so it is already high when the next strobe arrives.
  initial begin
    int         cnt;
    bit         gap;
    logic [7:0] held;
    cnt = 0; gap = 0; held = 8'd0;
    tx_busy = 1'b0;
    forever begin
      @(negedge bclk);
      if (rst) begin
        tx_busy = 1'b0; cnt = 0; gap = 0;
      end else if (tx_start) begin
        held = tx_data; cnt = busy_len; tx_busy = 1'b1; gap = 0;
      end else if (cnt > 0) begin
        check("tx_data_stable", {24'd0, tx_data}, {24'd0, held});
        cnt--;
        if (cnt == 0) begin
          tx_busy = 1'b0; gap = 1;
        end
      end else if (done) begin
        tx_busy = 1'b0; gap = 0;
      end else if (pre_hi && gap) begin
        tx_busy = 1'b1;
      end else begin
        tx_busy = 1'b0;
      end
    end
  end

  function automatic logic [143:0] fill(input logic [15:0] v);
    logic [143:0] r;
    for (int k = 0; k < 9; k++) r[k*16 +: 16] = v;
    return r;
  endfunction

  function automatic logic [143:0] res2();
    logic [143:0] r;
    r = '0;
    r[0*16 +: 16] = 16'h0001;
    r[1*16 +: 16] = 16'h0002;
    r[3*16 +: 16] = 16'h0003;
    r[4*16 +: 16] = 16'h00FF;
    return r;
  endfunction

  function automatic logic [143:0] res3();
    logic [143:0] r;
    for (int k = 0; k < 9; k++) r[k*16 +: 16] = 16'(16'h0102 * (k + 1));
    return r;
  endfunction

  task automatic push_stream2();
    exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    exp_q.push_back(8'h00); exp_q.push_back(8'h02);
    exp_q.push_back(8'h00); exp_q.push_back(8'h03);
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
    exp_q.push_back(8'h05);
  endtask

  task automatic push_ones();
    for (int k = 0; k < 18; k++) exp_q.push_back(8'h01);
    exp_q.push_back(8'h12);
  endtask

  task automatic run_xfer(input logic [3:0] sz, input logic [143:0] r, input int max_cyc);
    int d0;
    bit got;
    d0 = done_seen;
    got = 0;
    @(negedge bclk);
    size = sz; result = r; load = 1'b1;
    @(negedge bclk);
    load = 1'b0;
    for (int c = 0; c < max_cyc && !got; c++) begin
      @(negedge bclk);
      if (done_seen != d0) got = 1;
    end
    repeat (3) @(negedge bclk);
    check("done_pulses", done_seen - d0, 32'd1);
    check("stream_drained", exp_q.size(), 32'd0);
    check("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    s3 = '{8'h01, 8'h02, 8'h02, 8'h04, 8'h03, 8'h06, 8'h04, 8'h08, 8'h05, 8'h0A,
           8'h06, 8'h0C, 8'h07, 8'h0E, 8'h08, 8'h10, 8'h09, 8'h12, 8'h87};
    rst = 1'b1; load = 1'b0; result = '0; size = 4'd0;
    repeat (2) @(negedge bclk);
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge bclk);

    // 1x1 with a slow transmitter.
    busy_len = 10;
    exp_q.push_back(8'h12); exp_q.push_back(8'h34); exp_q.push_back(8'h46);
    run_xfer(4'd1, {128'd0, 16'h1234}, 1000);

    // 2x2 with checksum carry discarded.
    busy_len = 3;
    push_stream2();
    run_xfer(4'd2, res2(), 1000);

    // Out-of-range sizes fall back to 3x3.
    push_ones();
    run_xfer(4'd0, fill(16'h0101), 2000);
    push_ones();
    run_xfer(4'd9, fill(16'h0101), 2000);

    // A second load mid-transfer must be ignored.
    push_stream2();
    fork
      run_xfer(4'd2, res2(), 1000);
      begin
        repeat (20) @(negedge bclk);
        result = '1; size = 4'd3; load = 1'b1;
        @(negedge bclk);
        load = 1'b0;
      end
    join

    // Reset in WAIT_LO of the third byte, then a clean full transfer.
    busy_len = 10;
    for (int k = 0; k < 3; k++) exp_q.push_back(s3[k]);
    begin
      int s0;
      s0 = starts_seen;
      @(negedge bclk);
      size = 4'd3; result = res3(); load = 1'b1;
      @(negedge bclk);
      load = 1'b0;
      for (int c = 0; c < 500 && (starts_seen - s0) < 3; c++) @(negedge bclk);
      check("third_start_seen", starts_seen - s0, 32'd3);
      repeat (4) @(negedge bclk);
      rst = 1'b1;
      #1;
      check("abort_tx_start", {31'd0, tx_start}, 32'd0);
      check("abort_tx_data", {24'd0, tx_data}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      repeat (3) @(negedge bclk);
      rst = 1'b0;
      repeat (3) @(negedge bclk);
      check("abort_no_more_starts", starts_seen - s0, 32'd3);
      check("abort_queue_empty", exp_q.size(), 32'd0);
    end
    for (int k = 0; k < 19; k++) exp_q.push_back(s3[k]);
    run_xfer(4'd3, res3(), 2000);

    // Transmitter busy already high when each strobe fires.
    busy_len = 4;
    pre_hi = 1;
    push_stream2();
    run_xfer(4'd2, res2(), 1000);
    pre_hi = 0;
    repeat (3) @(negedge bclk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
